// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg: opcodes, reserved range, FSM states and delay-line entry for alu_resp_checker
package alu_chk_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_SHL = 4'b1101;
    localparam logic [3:0] OP_ROR = 4'b1110;
    localparam logic [3:0] OP_ROL = 4'b1111;
    localparam logic [3:0] RSV_LO = 4'b0010;
    localparam logic [3:0] RSV_HI = 4'b0111;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef struct packed {
        logic       valid;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctr;
    } entry_t;
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: expected ALU result; ALU_CHK_STRICT_EN makes reserved opcodes checkable (expect 0)
module alu_ref_model
    import alu_chk_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] CTR,
    output logic [7:0] exp,
    output logic       chk_en
);
    // 8-bit wrapping result per opcode; reserved opcodes expect zero
    always_comb begin
        exp = '0;
        case (CTR)
            OP_ADD:  exp = A + B;
            OP_SUB:  exp = A - B;
            OP_AND:  exp = A & B;
            OP_OR:   exp = A | B;
            OP_XOR:  exp = A ^ B;
            OP_NOT:  exp = ~A;
            OP_SHR:  exp = {1'b0, A[7:1]};
            OP_SHL:  exp = {A[6:0], 1'b0};
            OP_ROR:  exp = {A[0], A[7:1]};
            OP_ROL:  exp = {A[6:0], A[7]};
            default: exp = '0;
        endcase
    end
`ifdef ALU_CHK_STRICT_EN
    assign chk_en = 1'b1;
`else
    assign chk_en = !(CTR >= RSV_LO && CTR <= RSV_HI);
`endif
endmodule

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: delays ALU stimulus by LAT, compares with O0, counts and captures first failure (ALU_CHK_STRICT_EN checks reserved opcodes)
module alu_resp_checker
    import alu_chk_pkg::*;
#(
    parameter int LAT     = 2,
    parameter int NUM_VEC = 256
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [3:0]  CTR,
    input  logic [7:0]  O0,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] chk_cnt,
    output logic [15:0] err_cnt,
    output logic        fail_flag,
    output logic [7:0]  fail_A,
    output logic [7:0]  fail_B,
    output logic [3:0]  fail_CTR,
    output logic [7:0]  fail_exp,
    output logic [7:0]  fail_got
);
    state_t st, nxt;
    entry_t dl [LAT];
    logic [15:0] acc;
    logic [3:0] dcnt;
    logic [7:0] exp;
    logic chk_en, go, chk, mis;
    alu_ref_model u_ref (.A(dl[LAT-1].a), .B(dl[LAT-1].b), .CTR(dl[LAT-1].ctr), .exp(exp), .chk_en(chk_en));
    assign go   = start && (st == S_IDLE || st == S_DONE);
    assign busy = st == S_RUN || st == S_DRAIN;
    assign done = st == S_DONE;
    assign pass = done && err_cnt == '0;
    assign chk  = busy && dl[LAT-1].valid && chk_en;
    assign mis  = chk && exp != O0;
    // state register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= nxt;
    end
    // next state: run until NUM_VEC accepted, then drain LAT+1 edges so the last compare lands first
    always_comb begin
        nxt = st;
        case (st)
            S_IDLE, S_DONE: nxt = start ? S_RUN : st;
            S_RUN:          nxt = (in_valid && acc == 16'(NUM_VEC - 1)) ? S_DRAIN : st;
            S_DRAIN:        nxt = (dcnt == 4'(LAT)) ? S_DONE : st;
            default:        nxt = S_IDLE;
        endcase
    end
    // delay line: accepted vectors enter at the head, everything else is a bubble
    always_ff @(posedge ck or posedge rst) begin
        if (rst || go) begin
            for (int i = 0; i < LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= '{valid: st == S_RUN && in_valid, a: A, b: B, ctr: CTR};
            for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
        end
    end
    // accepted-vector and drain counters
    always_ff @(posedge ck or posedge rst) begin
        if (rst || go) begin
            acc  <= '0;
            dcnt <= '0;
        end else begin
            acc  <= (st == S_RUN && in_valid) ? acc + 16'd1 : acc;
            dcnt <= (st == S_DRAIN) ? dcnt + 4'd1 : dcnt;
        end
    end
    // result counters and first-failure capture
    always_ff @(posedge ck or posedge rst) begin
        if (rst || go) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            fail_flag <= 1'b0;
            fail_A    <= '0;
            fail_B    <= '0;
            fail_CTR  <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (chk) begin
            chk_cnt <= chk_cnt + 16'd1;
            if (mis) begin
                err_cnt <= (err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
                if (!fail_flag) begin
                    fail_flag <= 1'b1;
                    fail_A    <= dl[LAT-1].a;
                    fail_B    <= dl[LAT-1].b;
                    fail_CTR  <= dl[LAT-1].ctr;
                    fail_exp  <= exp;
                    fail_got  <= O0;
                end
            end
        end
    end
endmodule
